moore_run_detector: RTL

Parametrised Moore run-length detector. Counts consecutive occurrences of a selectable target bit on a serial input and flags a run of RUN_LEN bits. Extends the fixed 2-bit zero detector with configurable run length, target polarity, overlap mode, enable, and a saturating detection counter. Used wherever the design needs serial-line idle, preamble or stuck-bit detection.

---
 rtl/seq_det_pkg.sv | 12 +
 rtl/sat_counter.sv | 43 ++++
 rtl/moore_run_detector.sv | 63 ++++++
 3 files changed

// File: rtl/seq_det_pkg.sv
// Shared constants and width helpers for the serial sequence detectors.
package seq_det_pkg;

  localparam int unsigned DefRunLen = 3;
  localparam logic        DefTarget = 1'b0;

  // Width needed to hold a run counter spanning 0..run_len.
  function automatic int unsigned state_width(input int unsigned run_len);
    return (run_len < 2) ? 1 : $clog2(run_len + 1);
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating event counter with a sticky saturation flag and synchronous clear.
module sat_counter #(
  parameter int unsigned W = 8
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         clear,
  input  logic         inc,
  output logic [W-1:0] count,
  output logic         sat
);

  localparam logic [W-1:0] CountMax = {W{1'b1}};

  logic [W-1:0] count_q, count_d;
  logic         sat_q, sat_d;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      count_q <= '0;
      sat_q   <= 1'b0;
    end else begin
      count_q <= count_d;
      sat_q   <= sat_d;
    end
  end

  always_comb begin
    count_d = count_q;
    sat_d   = sat_q;
    if (clear) begin
      count_d = '0;
      sat_d   = 1'b0;
    end else begin
      if (inc && (count_q != CountMax)) count_d = count_q + W'(1);
      sat_d = sat_q | (count_d == CountMax);
    end
  end

  assign count = count_q;
  assign sat   = sat_q;

endmodule

// File: rtl/moore_run_detector.sv
// Moore detector for runs of RUN_LEN consecutive TARGET bits on a serial input,
// with overlap selection and a saturating detection counter.
module moore_run_detector
  import seq_det_pkg::*;
#(
  parameter int unsigned RUN_LEN = DefRunLen,
  parameter logic        TARGET  = DefTarget,
  parameter int unsigned CNT_W   = 8
) (
  input  logic                               clock,
  input  logic                               reset,
  input  logic                               en,
  input  logic                               clear,
  input  logic                               overlap,
  input  logic                               x_in,
  output logic [state_width(RUN_LEN)-1:0]    y_out,
  output logic                               detect,
  output logic [CNT_W-1:0]                   det_count,
  output logic                               cnt_sat
);

  localparam int unsigned        STATE_W = state_width(RUN_LEN);
  localparam logic [STATE_W-1:0] RunMax  = STATE_W'(RUN_LEN);

  logic [STATE_W-1:0] run_q, run_d;
  logic               hit;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) run_q <= '0;
    else        run_q <= run_d;
  end

  always_comb begin
    run_d = run_q;
    if (clear) begin
      run_d = '0;
    end else if (en) begin
      if (x_in != TARGET)     run_d = '0;
      else if (run_q != RunMax) run_d = run_q + STATE_W'(1);
      // A completed run either slides or restarts with the current bit as its first.
      else                    run_d = overlap ? RunMax : STATE_W'(1);
    end
  end

  assign hit = !clear && en && (run_d == RunMax);

  always_comb begin
    y_out  = run_q;
    detect = (run_q == RunMax);
  end

  sat_counter #(
    .W (CNT_W)
  ) u_sat_counter (
    .clock (clock),
    .reset (reset),
    .clear (clear),
    .inc   (hit),
    .count (det_count),
    .sat   (cnt_sat)
  );

endmodule
